// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Microcode sequencer for the 8-bit bus CPU. A micro-step counter walks
// through the fetch and execute steps of each instruction. The current
// opcode, the step and the ALU flags are decoded combinationally into the
// 16-bit control word that drives the shared bus.
//
// Parameters
//   STEPS      micro-steps per instruction (5..8). Steps past T4 decode to 0.
//   EARLY_END  1: an all-zero execute step (T2 or later) ends the instruction.
//
// Ports
//   clk     in   CPU clock
//   rst_n   in   asynchronous active-low reset
//   opcode  in   [3:0] instruction-register upper nibble, valid from T2
//   flag_c  in   registered ALU carry flag
//   flag_z  in   registered ALU zero flag
//   ctrl    out  [15:0] control word
//                [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO
//                [7]EO  [6]SU  [5]BI  [4]OI  [3]CE  [2]CO  [1]J  [0]FI
//   step    out  [2:0] current micro-step
//   halted  out  high once HLT has executed; cleared only by rst_n
// ---------------------------------------------------------------------------
module control_sequencer #(
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  // Control-word bit positions
  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  localparam logic [15:0] W_NONE  = 16'h0000;
  localparam logic [15:0] W_HLT   = 16'(1 << B_HLT);
  localparam logic [15:0] W_FETCH0 = 16'((1 << B_MI) | (1 << B_CO));
  localparam logic [15:0] W_FETCH1 = 16'((1 << B_RO) | (1 << B_II) | (1 << B_CE));
  localparam logic [15:0] W_IO_MI = 16'((1 << B_IO) | (1 << B_MI));
  localparam logic [15:0] W_RO_AI = 16'((1 << B_RO) | (1 << B_AI));
  localparam logic [15:0] W_RO_BI = 16'((1 << B_RO) | (1 << B_BI));
  localparam logic [15:0] W_ADD   = 16'((1 << B_EO) | (1 << B_AI) | (1 << B_FI));
  localparam logic [15:0] W_SUB   = 16'((1 << B_EO) | (1 << B_AI) | (1 << B_SU) | (1 << B_FI));
  localparam logic [15:0] W_AO_RI = 16'((1 << B_AO) | (1 << B_RI));
  localparam logic [15:0] W_IO_AI = 16'((1 << B_IO) | (1 << B_AI));
  localparam logic [15:0] W_JUMP  = 16'((1 << B_IO) | (1 << B_J));
  localparam logic [15:0] W_OUT   = 16'((1 << B_AO) | (1 << B_OI));

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  // Execute-step decode for one opcode. Only T2..T4 carry work; the
  // conditional jumps look at the flags in T2 and nowhere else.
  function automatic logic [15:0] f_exec(input logic [2:0] s,
                                         input logic [3:0] op,
                                         input logic       c,
                                         input logic       z);
    logic [15:0] w;
    w = W_NONE;
    case (op)
      OP_LDA: case (s)
                3'd2:    w = W_IO_MI;
                3'd3:    w = W_RO_AI;
                default: w = W_NONE;
              endcase
      OP_ADD: case (s)
                3'd2:    w = W_IO_MI;
                3'd3:    w = W_RO_BI;
                3'd4:    w = W_ADD;
                default: w = W_NONE;
              endcase
      OP_SUB: case (s)
                3'd2:    w = W_IO_MI;
                3'd3:    w = W_RO_BI;
                3'd4:    w = W_SUB;
                default: w = W_NONE;
              endcase
      OP_STA: case (s)
                3'd2:    w = W_IO_MI;
                3'd3:    w = W_AO_RI;
                default: w = W_NONE;
              endcase
      OP_LDI: w = (s == 3'd2) ? W_IO_AI : W_NONE;
      OP_JMP: w = (s == 3'd2) ? W_JUMP  : W_NONE;
      OP_JC:  w = (s == 3'd2 && c) ? W_JUMP : W_NONE;
      OP_JZ:  w = (s == 3'd2 && z) ? W_JUMP : W_NONE;
      OP_OUT: w = (s == 3'd2) ? W_OUT   : W_NONE;
      OP_HLT: w = (s == 3'd2) ? W_HLT   : W_NONE;
      // NOP and the undefined opcodes 0x9..0xD do nothing
      default: w = W_NONE;
    endcase
    return w;
  endfunction

  // Full control-word decode: fetch steps are opcode independent, steps
  // past T4 are always empty.
  function automatic logic [15:0] f_decode(input logic [2:0] s,
                                           input logic [3:0] op,
                                           input logic       c,
                                           input logic       z);
    logic [15:0] w;
    case (s)
      3'd0:                w = W_FETCH0;
      3'd1:                w = W_FETCH1;
      3'd2, 3'd3, 3'd4:    w = f_exec(s, op, c, z);
      default:             w = W_NONE;
    endcase
    return w;
  endfunction

  logic [2:0]  r_step;
  logic        r_halted;
  logic [15:0] w_ctrl;
  logic [2:0]  w_step_nxt;
  logic        w_halt_set;

  // Once halted the word is pinned to HLT regardless of inputs.
  always_comb begin
    w_ctrl = W_HLT;
    if (!r_halted) begin
      w_ctrl = f_decode(r_step, opcode, flag_c, flag_z);
    end
  end

  // HLT takes effect at the end of its T2; the step counter then freezes.
  assign w_halt_set = !r_halted && (r_step == 3'd2) && (opcode == OP_HLT);

  always_comb begin
    w_step_nxt = r_step + 3'd1;
    if (r_halted || w_halt_set) begin
      w_step_nxt = r_step;
    end else if (r_step >= LAST_STEP) begin
      w_step_nxt = 3'd0;
    end else if (EARLY_END && (r_step >= 3'd2) && (w_ctrl == W_NONE)) begin
      w_step_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= 3'd0;
      r_halted <= 1'b0;
    end else begin
      r_step <= w_step_nxt;
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign ctrl   = w_ctrl;
  assign step   = r_step;
  assign halted = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: STEPS=5 EARLY_END=1; 1: STEPS=5 EARLY_END=0; 2: STEPS=8 EARLY_END=0
  logic        rst_n_a [3];
  logic [3:0]  opc_a   [3];
  logic        fc_a    [3];
  logic        fz_a    [3];
  logic [15:0] ctrl_a  [3];
  logic [2:0]  step_a  [3];
  logic        halt_a  [3];

  control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n_a[0]), .opcode(opc_a[0]), .flag_c(fc_a[0]),
    .flag_z(fz_a[0]), .ctrl(ctrl_a[0]), .step(step_a[0]), .halted(halt_a[0]));

  control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n_a[1]), .opcode(opc_a[1]), .flag_c(fc_a[1]),
    .flag_z(fz_a[1]), .ctrl(ctrl_a[1]), .step(step_a[1]), .halted(halt_a[1]));

  control_sequencer #(.STEPS(8), .EARLY_END(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n_a[2]), .opcode(opc_a[2]), .flag_c(fc_a[2]),
    .flag_z(fz_a[2]), .ctrl(ctrl_a[2]), .step(step_a[2]), .halted(halt_a[2]));

  typedef struct {
    int          idx;
    logic [19:0] exp;   // {ctrl, step, halted}
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_w [8];

  // Compare the oldest scoreboard entry against the DUT it names.
  task automatic compare_head();
    exp_t        e;
    logic [19:0] obs;
    e   = sb_q.pop_front();
    obs = {ctrl_a[e.idx], step_a[e.idx], halt_a[e.idx]};
    tests++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s: observed ctrl=%h step=%0d halted=%b, expected ctrl=%h step=%0d halted=%b",
             e.tag, obs[19:4], obs[3:1], obs[0], e.exp[19:4], e.exp[3:1], e.exp[0]);
    end
  endtask

  // Expect a value at the next falling edge (mid-cycle sample).
  task automatic check_cycle(input int idx, input logic [19:0] exp, input string tag);
    exp_t e;
    e.idx = idx; e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    compare_head();
  endtask

  // Expect a value right now, without waiting for any clock edge.
  task automatic check_now(input int idx, input logic [19:0] exp, input string tag);
    exp_t e;
    e.idx = idx; e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
    compare_head();
  endtask

  // Drive one instruction and expect exp_w[0..n-1] on consecutive cycles
  // with step counting 0..n-1. Returns just after the edge ending step n-1.
  task automatic do_instr(input int idx, input logic [3:0] op, input logic c,
                          input logic z, input int n, input string tag);
    opc_a[idx] = op; fc_a[idx] = c; fz_a[idx] = z;
    for (int k = 0; k < n; k++) begin
      check_cycle(idx, {exp_w[k], 3'(k), 1'b0}, $sformatf("%s_T%0d", tag, k));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n_a[i] = 1'b0; opc_a[i] = 4'h0; fc_a[i] = 1'b0; fz_a[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_now(i, {16'h4004, 3'd0, 1'b0}, $sformatf("reset%0d", i));

    rst_n_a[0] = 1'b1;
    exp_w = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281, 0, 0, 0};
    do_instr(0, 4'h2, 1'b0, 1'b0, 5, "add");
    exp_w = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h02C1, 0, 0, 0};
    do_instr(0, 4'h3, 1'b0, 1'b0, 5, "sub");
    exp_w = '{16'h4004, 16'h1408, 16'h0802, 16'h0000, 0, 0, 0, 0};
    do_instr(0, 4'h8, 1'b0, 1'b1, 4, "jz_taken");
    exp_w = '{16'h4004, 16'h1408, 16'h0000, 0, 0, 0, 0, 0};
    do_instr(0, 4'h8, 1'b1, 1'b0, 3, "jz_untaken");
    exp_w = '{16'h4004, 16'h1408, 16'h0802, 16'h0000, 0, 0, 0, 0};
    do_instr(0, 4'h7, 1'b1, 1'b0, 4, "jc_taken");
    exp_w = '{16'h4004, 16'h1408, 16'h0000, 0, 0, 0, 0, 0};
    do_instr(0, 4'h7, 1'b0, 1'b1, 3, "jc_untaken");
    do_instr(0, 4'h0, 1'b0, 1'b0, 3, "nop");
    do_instr(0, 4'hB, 1'b1, 1'b1, 3, "illegal_b");
    exp_w = '{16'h4004, 16'h1408, 16'h4800, 16'h2100, 16'h0000, 0, 0, 0};
    do_instr(0, 4'h4, 1'b0, 1'b0, 5, "sta");
    exp_w = '{16'h4004, 16'h1408, 16'h0110, 16'h0000, 0, 0, 0, 0};
    do_instr(0, 4'hE, 1'b0, 1'b0, 4, "out");

    // Reset in the middle of LDA T3, then restart with LDI
    exp_w = '{16'h4004, 16'h1408, 16'h4800, 0, 0, 0, 0, 0};
    do_instr(0, 4'h1, 1'b0, 1'b0, 3, "lda");
    check_now(0, {16'h1200, 3'd3, 1'b0}, "lda_T3");
    #1 rst_n_a[0] = 1'b0;
    #1 check_now(0, {16'h4004, 3'd0, 1'b0}, "reset_mid_lda");
    #1 rst_n_a[0] = 1'b1;
    exp_w = '{16'h4004, 16'h1408, 16'h0A00, 16'h0000, 0, 0, 0, 0};
    do_instr(0, 4'h5, 1'b0, 1'b0, 4, "ldi_after_reset");

    // HLT: freezes at step 2 with ctrl 0x8000 while inputs toggle
    exp_w = '{16'h4004, 16'h1408, 16'h8000, 0, 0, 0, 0, 0};
    do_instr(0, 4'hF, 1'b0, 1'b0, 3, "hlt");
    for (int k = 0; k < 20; k++) begin
      opc_a[0] = 4'($urandom_range(0, 15));
      fc_a[0]  = 1'($urandom_range(0, 1));
      fz_a[0]  = 1'($urandom_range(0, 1));
      check_cycle(0, {16'h8000, 3'd2, 1'b1}, $sformatf("halted_%0d", k));
      @(posedge clk); #1;
    end
    opc_a[0] = 4'h0;
    rst_n_a[0] = 1'b0;
    #1 check_now(0, {16'h4004, 3'd0, 1'b0}, "halt_reset");
    #1 rst_n_a[0] = 1'b1;
    exp_w = '{16'h4004, 16'h1408, 16'h0000, 0, 0, 0, 0, 0};
    do_instr(0, 4'h0, 1'b0, 1'b0, 3, "nop_after_halt");

    // EARLY_END=0: NOP runs all five steps
    rst_n_a[1] = 1'b1;
    exp_w = '{16'h4004, 16'h1408, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0};
    do_instr(1, 4'h0, 1'b0, 1'b0, 5, "ee0_nop");
    check_cycle(1, {16'h4004, 3'd0, 1'b0}, "ee0_wrap");
    @(posedge clk); #1;

    // STEPS=8: ADD with empty T5..T7, wrap 7->0
    rst_n_a[2] = 1'b1;
    exp_w = '{16'h4004, 16'h1408, 16'h4800, 16'h1020, 16'h0281, 16'h0000, 16'h0000, 16'h0000};
    do_instr(2, 4'h2, 1'b0, 1'b0, 8, "s8_add");
    check_cycle(2, {16'h4004, 3'd0, 1'b0}, "s8_wrap");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer for the 8-bit bus CPU.
- Steps through fetch/execute micro-steps on the CPU clock and decodes the instruction-register opcode plus ALU flags into a 16-bit control word.
- The control word drives the program counter (CE/CO/J), memory, registers, ALU and output register on the shared bus.
- Replaces the hard-tied pc_inc/pc_out/pc_jump controls in the top level.

Parameters:
- STEPS, 5: micro-steps per instruction, legal range 5..8; steps beyond T4 decode to 0x0000.
- EARLY_END, 1: when 1, an all-zero execute step (T2 or later) ends the instruction early.

Ports:
- clk  input  1  CPU clock (the cpu_clk output of the clock module)
- rst_n  input  1  asynchronous active-low reset
- opcode  input  4  instruction-register upper nibble; valid from T2 onward
- flag_c  input  1  registered ALU carry flag
- flag_z  input  1  registered ALU zero flag
- ctrl  output  16  control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI
- step  output  3  current micro-step T0..T(STEPS-1)
- halted  output  1  high once HLT has executed

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n low, any time, including mid-instruction): step=0 and halted=0 immediately. ctrl therefore equals the T0 word 0x4004.
- Registered state: step counter and halted only. ctrl is a combinational decode of (step, opcode, flag_c, flag_z, halted) and is valid for the whole cycle.
- Fetch, independent of opcode:
  - T0 = MI|CO (0x4004)
  - T1 = RO|II|CE (0x1408)
- Execute words (T2/T3/T4; unlisted steps are 0x0000):
  - 0x0 NOP: none
  - 0x1 LDA: IO|MI (0x4800) / RO|AI (0x1200)
  - 0x2 ADD: 0x4800 / RO|BI (0x1020) / EO|AI|FI (0x0281)
  - 0x3 SUB: 0x4800 / 0x1020 / EO|AI|SU|FI (0x02C1)
  - 0x4 STA: 0x4800 / AO|RI (0x2100)
  - 0x5 LDI: IO|AI (0x0A00)
  - 0x6 JMP: IO|J (0x0802)
  - 0x7 JC: 0x0802 if flag_c else 0x0000
  - 0x8 JZ: 0x0802 if flag_z else 0x0000
  - 0xE OUT: AO|OI (0x0110)
  - 0xF HLT: HLT (0x8000)
  - 0x9-0xD: undefined, decode as NOP
- Flags are sampled combinationally during T2 only.
- Next-step rule on each rising edge, when not halted:
  - step -> 0 if step == STEPS-1;
  - else step -> 0 if EARLY_END=1, step >= 2 and the ctrl word is 0x0000;
  - else step -> step+1.
- The empty step that triggers an early end is still a full cycle. Resulting instruction lengths with EARLY_END=1, STEPS=5:
  - NOP: 3 cycles
  - LDI, JMP, OUT: 4 cycles
  - untaken JC/JZ: 3 cycles
  - STA: 5 cycles (T4 empty, wraps anyway)
  - ADD/SUB: 5 cycles
- Wrap from STEPS-1 to 0 always occurs; step never exceeds STEPS-1.
- HLT:
  - At the edge ending the HLT T2 cycle, halted goes to 1 and step freezes at 2.
  - While halted, ctrl = 0x8000 constantly; opcode and flag changes are ignored.
  - Only rst_n exits halt.
- No CE/CO/J combination other than the words above is ever produced. J and CE are never asserted in the same cycle.

Test Plan:
- Reset mid-instruction: assert rst_n low at LDA T3 -> step=0, halted=0, ctrl=0x4004 without waiting for a clock edge. Release -> T0/T1 words 0x4004, 0x1408 on successive cycles.
- ADD with EARLY_END=1: opcode=0x2 -> ctrl sequence 0x4004, 0x1408, 0x4800, 0x1020, 0x0281, then step=0.
- Conditional jump: opcode=0x8 with flag_z=1 -> T2=0x0802, then empty T3 and step=0 (4 cycles). With flag_z=0 -> T2=0x0000, step=0 after 3 cycles. Repeat for JC with flag_c.
- EARLY_END=0: opcode=0x0 (NOP) -> five cycles (0x4004, 0x1408, 0, 0, 0) before step returns to 0.
- HLT: opcode=0xF -> T2 ctrl=0x8000; after the next edge halted=1, step stays 2 and ctrl stays 0x8000 for 20 cycles while opcode toggles. rst_n pulse -> halted=0, ctrl=0x4004.
- Illegal opcode 0xB -> behaves exactly as NOP (3 cycles, execute words 0x0000). STEPS=8, EARLY_END=0, opcode=0x2 -> T5..T7 = 0x0000 and step wraps 7->0.
